// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_arith_pkg
//  Purpose  : Shared types and bit-cell truth tables for the bit-serial
//             arithmetic blocks (serial subtractor / serial adder).
//  Revision : 1.0  initial release
// ============================================================================
package serial_arith_pkg;

    // Sequencer states shared by the serial arithmetic units
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-cell truth tables, indexed by {a, b, carry/borrow}.
    // Difference and sum are both the 3-input parity.
    localparam logic [7:0] FS_DIFF_TT   = 8'h96;
    // Borrow: (~a & b) | (~(a ^ b) & br)
    localparam logic [7:0] FS_BORROW_TT = 8'h8E;
    localparam logic [7:0] FA_SUM_TT    = 8'h96;
    // Carry: majority(a, b, c)
    localparam logic [7:0] FA_CARRY_TT  = 8'hE8;

    // Value the borrow/carry flip-flop holds when no operation is active
    localparam logic       BR_CLEAR     = 1'b0;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_subtractor_bit.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor_bit
//  Purpose  : Combinational one-bit full subtractor cell: d = a - b - br.
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor_bit
    import serial_arith_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_next_o
);

    logic [2:0] w_idx;

    // Look the cell outputs up in the shared truth tables
    always_comb begin
        w_idx     = {a_i, b_i, br_i};
        d_o       = FS_DIFF_TT[w_idx];
        br_next_o = FS_BORROW_TT[w_idx];
    end

endmodule : full_subtractor_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial subtractor. Computes (a - b - bin) mod 2^W one bit
//             per clock, LSB first, through a single borrow flip-flop, and
//             returns a parallel difference, borrow-out and done strobe.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int W  = 6,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,       // asynchronous, active-low
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         diff_bit,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic          br_q,    br_d;
    logic [W-1:0]  res_q,   res_d;
    logic [W-1:0]  diff_q,  diff_d;
    logic          bout_q,  bout_d;

    logic          w_d;
    logic          w_br_next;
    logic [W:0]    w_res_ext;

    full_subtractor_bit u_cell (
        .a_i       (a_q[0]),
        .b_i       (b_q[0]),
        .br_i      (br_q),
        .d_o       (w_d),
        .br_next_o (w_br_next)
    );

    // New bit enters from the MSB side; the extended vector keeps W = 1 legal
    assign w_res_ext = {w_d, res_q};

    // Next-state, datapath and result-capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = w_res_ext[W:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = w_br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    diff_d  = w_res_ext[W:1];
                    bout_d  = w_br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= BR_CLEAR;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy     = (state_q == SHIFT) || (state_q == DONE);
        done     = (state_q == DONE);
        diff_bit = (state_q == SHIFT) ? w_d : 1'b0;
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Directed self-checking bench for serial_subtractor (W = 6).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         diff_bit;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .diff_bit (diff_bit),
        .done     (done),
        .diff     (diff),
        .bout     (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Runs one operation starting at a negedge. Operand inputs are scrambled
    // after the load edge. If glitch_at >= 0, a stray start (a=1, b=1) is
    // raised for one cycle at that SHIFT cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input logic [W-1:0] ediff,
                          input logic ebout, input int glitch_at);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        check("idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        for (int i = 0; i < W; i++) begin
            check($sformatf("shift%0d_busy", i), busy, 1);
            check($sformatf("shift%0d_done", i), done, 0);
            check($sformatf("shift%0d_bit", i), diff_bit, ediff[i]);
            if (i == glitch_at) begin
                start = 1'b1; a = 6'd1; b = 6'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_strobe", done, 1);
        check("done_busy", busy, 1);
        check("done_bit", diff_bit, 0);
        check("diff", diff, ediff);
        check("bout", bout, ebout);
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("hold_diff", diff, ediff);
        check("hold_bout", bout, ebout);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_bit", diff_bit, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_rst", busy, 0);

        // Main function: 25 = 011001 -> LSB-first bits 1,0,0,1,1,0
        run_op(6'd45, 6'd20, 1'b0, 6'd25, 1'b0, -1);
        run_op(6'd20, 6'd45, 1'b0, 6'd39, 1'b1, -1);
        run_op(6'd0,  6'd0,  1'b1, 6'd63, 1'b1, -1);
        run_op(6'd63, 6'd63, 1'b0, 6'd0,  1'b0, -1);

        // Stray start during SHIFT: 50 - 7 - 1 = 42, not queued
        run_op(6'd50, 6'd7, 1'b1, 6'd42, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_queue_busy", busy, 0);
            check("no_queue_done", done, 0);
        end
        // New start accepted after returning to IDLE
        run_op(6'd1, 6'd1, 1'b0, 6'd0, 1'b0, -1);
        run_op(6'd33, 6'd2, 1'b1, 6'd30, 1'b0, -1);

        // Asynchronous reset during SHIFT cycle 3
        a = 6'd45; b = 6'd20; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", bout, 0);
        check("arst_bit", diff_bit, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        run_op(6'd10, 6'd3, 1'b0, 6'd7, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
